// File: rtl/oclib_fifo.sv
// First-word-fall-through FIFO with a Depth x Width register array, count-based full/empty and an almostFull threshold.
// Optional simulation checks are enabled with OCLIB_FIFO_CHECK_EN.
module oclib_fifo #(
    parameter int Width      = 32,
    parameter int Depth      = 8,
    parameter int AlmostFull = Depth - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] inData,
    input  logic             inValid,
    output logic             inReady,
    output logic [Width-1:0] outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             almostFull
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    // Handshake outputs come only from registered count, so inReady never sees outReady.
    assign inReady  = !reset && (count_q < CntFull);
    assign outValid = !reset && (count_q != '0);
    assign outData  = mem_q[rd_ptr_q];

    assign push = inValid && inReady;
    assign pop  = outValid && outReady;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= inData;
        end
    end

    generate
        if (AlmostFull <= 0) begin : g_af_one
            assign almostFull = 1'b1;
        end else if (AlmostFull > Depth) begin : g_af_zero
            assign almostFull = 1'b0;
        end else begin : g_af_cmp
            assign almostFull = !reset && (count_q >= CntW'(AlmostFull));
        end
    endgenerate

`ifdef OCLIB_FIFO_CHECK_EN
    logic [Width-1:0] hold_data_q;
    logic             hold_q;

    initial begin
        if (Depth < 2) $error("oclib_fifo: Depth %0d below 2", Depth);
        if (Width < 1) $error("oclib_fifo: Width %0d below 1", Width);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= 1'b0;
        end else begin
            hold_q      <= outValid && !outReady;
            hold_data_q <= outData;
            if (count_q > CntFull) $error("oclib_fifo: occupancy %0d exceeds Depth", count_q);
            if (hold_q && outValid && (outData != hold_data_q)) $error("oclib_fifo: outData changed while stalled");
        end
    end
`endif

endmodule

// File: tb/tb_oclib_fifo.sv
// Directed bench for oclib_fifo at Width=8, Depth=4, AlmostFull=2 with hand-computed expectations.
module tb_oclib_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] inData;
    logic       inValid;
    logic       inReady;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       almostFull;

    int n_chk = 0;
    int n_err = 0;

    oclib_fifo #(.Width(8), .Depth(4), .AlmostFull(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .inData     (inData),
        .inValid    (inValid),
        .inReady    (inReady),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady),
        .almostFull (almostFull)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        inData  = d;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, 32'(outValid), 32'd1);
        chk({tag, "_dat"}, 32'(outData), 32'(exp));
        outReady = 1'b1;
        step();
        outReady = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        inData   = '0;
        inValid  = 1'b0;
        outReady = 1'b0;
        step();
        step();
        chk("rst_inready", 32'(inReady), 32'd0);
        chk("rst_outvalid", 32'(outValid), 32'd0);
        chk("rst_af", 32'(almostFull), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_inready", 32'(inReady), 32'd1);
        chk("idle_outvalid", 32'(outValid), 32'd0);
        chk("idle_af", 32'(almostFull), 32'd0);

        // fill with consumer stalled
        push(8'h11);
        chk("fill1_vld", 32'(outValid), 32'd1);
        chk("fill1_dat", 32'(outData), 32'h11);
        chk("fill1_af", 32'(almostFull), 32'd0);
        push(8'h22);
        chk("fill2_af", 32'(almostFull), 32'd1);
        chk("fill2_dat", 32'(outData), 32'h11);
        push(8'h33);
        chk("fill3_rdy", 32'(inReady), 32'd1);
        push(8'h44);
        chk("fill4_rdy", 32'(inReady), 32'd0);
        push(8'h55);
        chk("fill5_rdy", 32'(inReady), 32'd0);
        chk("fill5_dat", 32'(outData), 32'h11);

        pop_chk("drain1", 8'h11);
        pop_chk("drain2", 8'h22);
        pop_chk("drain3", 8'h33);
        pop_chk("drain4", 8'h44);
        chk("drain_empty", 32'(outValid), 32'd0);
        chk("drain_af", 32'(almostFull), 32'd0);

        // full: write attempt and pop in the same cycle
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        inData   = 8'h77;
        inValid  = 1'b1;
        outReady = 1'b1;
        step();
        inValid  = 1'b0;
        outReady = 1'b0;
        chk("fullpp_rdy", 32'(inReady), 32'd1);
        chk("fullpp_af", 32'(almostFull), 32'd1);
        pop_chk("fullpp1", 8'h62);
        pop_chk("fullpp2", 8'h63);
        pop_chk("fullpp3", 8'h64);
        chk("fullpp_empty", 32'(outValid), 32'd0);

        // streaming with two entries resident
        push(8'h80);
        push(8'h81);
        for (int k = 0; k < 10; k++) begin
            chk("stream_dat", 32'(outData), 32'(8'h80 + k));
            chk("stream_af", 32'(almostFull), 32'd1);
            inData   = 8'(8'h82 + k);
            inValid  = 1'b1;
            outReady = 1'b1;
            step();
        end
        inValid  = 1'b0;
        outReady = 1'b0;
        chk("stream_rdy", 32'(inReady), 32'd1);
        pop_chk("stream_t1", 8'h8A);
        pop_chk("stream_t2", 8'h8B);
        chk("stream_empty", 32'(outValid), 32'd0);

        // pop request on empty FIFO is ignored
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("emptypop_vld", 32'(outValid), 32'd0);
        push(8'h3C);
        pop_chk("emptypop_next", 8'h3C);

        // reset mid-operation discards contents
        push(8'h91);
        push(8'h92);
        push(8'h93);
        reset = 1'b1;
        step();
        chk("midrst_vld", 32'(outValid), 32'd0);
        chk("midrst_rdy", 32'(inReady), 32'd0);
        reset = 1'b0;
        step();
        chk("postrst_vld", 32'(outValid), 32'd0);
        chk("postrst_rdy", 32'(inReady), 32'd1);
        push(8'hA5);
        pop_chk("postrst_first", 8'hA5);
        chk("postrst_empty", 32'(outValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/oclib_fifo.md
OCLIB_FIFO -- requirements
Module: oclib_fifo

Interface
REQ-001 SHALL have parameter Width, default 32: data bits per entry, legal range >=1.
REQ-002 SHALL have parameter Depth, default 8: entries of storage, legal range >=2; non-power-of-two legal.
REQ-003 SHALL have parameter AlmostFull, default Depth-1: occupancy threshold for almostFull, signed int.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port inData  input  Width  write data.
REQ-007 SHALL have port inValid  input  1  write request.
REQ-008 SHALL have port inReady  output  1  FIFO can accept a write this cycle.
REQ-009 SHALL have port outData  output  Width  head-of-queue data.
REQ-010 SHALL have port outValid  output  1  head entry is valid.
REQ-011 SHALL have port outReady  input  1  consumer accepts head this cycle.
REQ-012 SHALL have port almostFull  output  1  occupancy at/above AlmostFull.

Function
REQ-013 SHALL push inData when inValid && inReady at a rising edge; SHALL pop when outValid && outReady.
REQ-014 SHALL be first-word-fall-through: outData is the oldest entry whenever outValid=1, with no read latency.
REQ-015 SHALL assert outValid exactly when occupancy >0; a push into an empty FIFO SHALL appear on outValid/outData the next cycle (1-cycle latency).
REQ-016 SHALL drive inReady = (occupancy < Depth) outside reset; inReady SHALL NOT depend combinationally on outReady.
REQ-017 SHALL, when full, refuse pushes even if a pop occurs the same cycle; occupancy then decrements by 1.
REQ-018 SHALL, on simultaneous push and pop with 0<occupancy<Depth, keep occupancy unchanged and preserve order.
REQ-019 SHALL hold outData stable while outValid=1 and outReady=0.
REQ-020 SHALL keep occupancy in a register of $clog2(Depth+1) bits; read/write pointers SHALL wrap from Depth-1 to 0.
REQ-021 SHALL drive almostFull = (occupancy >= AlmostFull), from registered state; AlmostFull<=0 SHALL make it constant 1; AlmostFull>Depth SHALL make it constant 0.
REQ-022 SHALL ignore inValid when inReady=0 and outReady when outValid=0 (no state change, no error).
REQ-023 SHALL preserve data exactly, bit-for-bit, in arrival order.

Reset
REQ-024 SHALL, while reset=1, clear occupancy and both pointers, drive inReady=0, outValid=0, almostFull=(AlmostFull<=0).
REQ-025 SHALL, on reset asserted mid-operation, discard all stored entries at the next rising edge; storage contents need not be cleared.
REQ-026 SHALL drive inReady=1 in the first cycle after reset deasserts.
REQ-027 SHALL leave outData undefined-but-stable content while outValid=0.

Configuration
REQ-028 SHALL support macro OCLIB_FIFO_CHECK_EN; when defined, simulation checks SHALL report an error ($error) if Depth<2, Width<1, occupancy>Depth, or outData changes while outValid && !outReady.
REQ-029 SHALL, without OCLIB_FIFO_CHECK_EN, contain no checking code and behave identically otherwise.

Structure
REQ-030 SHALL need no package typedefs; data is a flat Width vector, callers pass $bits(struct).
REQ-031 SHALL be a single module with no sub-modules; storage is an internal Depth x Width array.
REQ-032 SHALL be independent of sibling library block oclib_pipeline (fixed-latency delay line), which is specified separately.

Verification (Width=8, Depth=4, AlmostFull=2)
REQ-033 Reset then idle -> inReady=1, outValid=0, almostFull=0 one cycle after reset drops.
REQ-034 Push 0x11,0x22,0x33,0x44 with outReady=0 -> inReady=0 after 4th push, almostFull=1 after 2nd push; 5th push 0x55 ignored.
REQ-035 Full FIFO, outReady=1 for 4 cycles -> outData 0x11,0x22,0x33,0x44 in order, then outValid=0.
REQ-036 Continuous push+pop with 2 entries stored over 10 cycles -> occupancy stays 2, pointers wrap, order preserved.
REQ-037 Full FIFO, inValid=1 and outReady=1 same cycle -> one pop, no push, occupancy 3, inReady=1 next cycle.
REQ-038 Reset asserted with 3 entries stored -> outValid=0 next cycle; subsequent push 0xA5 emerges first.
